// File: rtl/dt_mode_ctrl.sv
// dT source controller: sequences the internal estimator (init, warm-up, stale
// detection) and selects between the external dT and the estimator output.
module dt_mode_ctrl #(
  parameter int WARM_SAMPLES = 4,
  parameter int TIMEOUT_CYC  = 1024,
  parameter int CW           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       dt_mode,
  input  logic       t_valid,
  input  logic [7:0] T_in,
  input  logic [7:0] dT_ext,
  input  logic       dT_ext_valid,
  input  logic [7:0] est_dT,
  input  logic       est_valid,
  output logic [7:0] est_T,
  output logic       est_init,
  output logic [7:0] dT_out,
  output logic       dT_valid,
  output logic [1:0] state,
  output logic       stale
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [7:0]    WARM_LAST = 8'(WARM_SAMPLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);
  localparam bit            TO_EN     = (TIMEOUT_CYC != 0);

  state_t        state_reg, state_next;
  logic [7:0]    est_t_reg, est_t_next;
  logic          est_init_reg, est_init_next;
  logic [7:0]    dt_out_reg, dt_out_next;
  logic          dt_valid_reg, dt_valid_next;
  logic          stale_reg, stale_next;
  logic [7:0]    warm_cnt_reg, warm_cnt_next;
  logic [CW-1:0] to_cnt_reg, to_cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      est_t_reg    <= '0;
      est_init_reg <= 1'b0;
      dt_out_reg   <= '0;
      dt_valid_reg <= 1'b0;
      stale_reg    <= 1'b0;
      warm_cnt_reg <= '0;
      to_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      est_t_reg    <= est_t_next;
      est_init_reg <= est_init_next;
      dt_out_reg   <= dt_out_next;
      dt_valid_reg <= dt_valid_next;
      stale_reg    <= stale_next;
      warm_cnt_reg <= warm_cnt_next;
      to_cnt_reg   <= to_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    est_t_next    = est_t_reg;
    est_init_next = 1'b0;
    dt_out_next   = dt_out_reg;
    dt_valid_next = 1'b0;
    stale_next    = stale_reg;
    warm_cnt_next = warm_cnt_reg;
    to_cnt_next   = to_cnt_reg;

    if (!enable) begin
      state_next = IDLE;
    end else if (!dt_mode) begin
      // External path: abort wins over any same-cycle sample.
      state_next    = IDLE;
      dt_out_next   = dT_ext;
      dt_valid_next = dT_ext_valid;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (t_valid) begin
            est_t_next    = T_in;
            est_init_next = 1'b1;
            stale_next    = 1'b0;
            warm_cnt_next = '0;
            state_next    = WARM;
          end
        end
        WARM: begin
          if (t_valid) begin
            est_t_next    = T_in;
            warm_cnt_next = warm_cnt_reg + 8'd1;
            if (warm_cnt_reg == WARM_LAST) begin
              state_next  = RUN;
              to_cnt_next = '0;
            end
          end
        end
        RUN: begin
          dt_out_next   = est_dT;
          dt_valid_next = est_valid;
          if (t_valid) begin
            est_t_next  = T_in;
            to_cnt_next = '0;
          end else begin
            if (to_cnt_reg != '1)
              to_cnt_next = to_cnt_reg + 1'b1;
            // A sample arriving on the expiry cycle takes the branch above.
            if (TO_EN && (to_cnt_reg == TO_LAST)) begin
              stale_next    = 1'b1;
              dt_valid_next = 1'b0;
              state_next    = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign state    = state_reg;
  assign est_T    = est_t_reg;
  assign est_init = est_init_reg;
  assign dT_out   = dt_out_reg;
  assign dT_valid = dt_valid_reg;
  assign stale    = stale_reg;

endmodule

// File: tb/tb_dt_mode_ctrl.sv
// Scoreboard bench for dt_mode_ctrl: the driver queues hand-computed expected
// outputs per cycle, a monitor pops and compares them after each clock edge.
module tb_dt_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       dt_mode = 1'b0;
  logic       t_valid = 1'b0;
  logic [7:0] T_in = '0;
  logic [7:0] dT_ext = '0;
  logic       dT_ext_valid = 1'b0;
  logic [7:0] est_dT = '0;
  logic       est_valid = 1'b0;
  logic [7:0] est_T;
  logic       est_init;
  logic [7:0] dT_out;
  logic       dT_valid;
  logic [1:0] state;
  logic       stale;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dt_mode_ctrl #(.WARM_SAMPLES(4), .TIMEOUT_CYC(16), .CW(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .dt_mode(dt_mode),
    .t_valid(t_valid), .T_in(T_in), .dT_ext(dT_ext),
    .dT_ext_valid(dT_ext_valid), .est_dT(est_dT), .est_valid(est_valid),
    .est_T(est_T), .est_init(est_init), .dT_out(dT_out),
    .dT_valid(dT_valid), .state(state), .stale(stale)
  );

  typedef struct {
    string      name;
    logic [7:0] st;
    logic [7:0] et;
    logic [7:0] ini;
    logic [7:0] dto;
    logic [7:0] dv;
    logic [7:0] stl;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input string fld,
                     input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s actual=%0d required=%0d", nm, fld,
               $signed(act), $signed(req));
    end
  endtask

  // Monitor: every cycle after an edge the DUT presents a full output set.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "state",    {6'd0, state},    e.st);
      chk(e.name, "est_T",    est_T,            e.et);
      chk(e.name, "est_init", {7'd0, est_init}, e.ini);
      chk(e.name, "dT_out",   dT_out,           e.dto);
      chk(e.name, "dT_valid", {7'd0, dT_valid}, e.dv);
      chk(e.name, "stale",    {7'd0, stale},    e.stl);
      $display("txn %-12s state=%0d est_T=%0d init=%0b dT_out=%0d dT_valid=%0b stale=%0b",
               e.name, state, $signed(est_T), est_init, $signed(dT_out),
               dT_valid, stale);
    end
  end

  task automatic step(input string nm, input int r, input int en, input int md,
                      input int tv, input int t, input int dx, input int dxv,
                      input int ed, input int ev,
                      input int st, input int et, input int ini, input int dto,
                      input int dv, input int stl);
    exp_t e;
    @(negedge clk);
    rst          = r[0];
    enable       = en[0];
    dt_mode      = md[0];
    t_valid      = tv[0];
    T_in         = 8'(t);
    dT_ext       = 8'(dx);
    dT_ext_valid = dxv[0];
    est_dT       = 8'(ed);
    est_valid    = ev[0];
    e.name = nm;
    e.st   = 8'(st);
    e.et   = 8'(et);
    e.ini  = 8'(ini);
    e.dto  = 8'(dto);
    e.dv   = 8'(dv);
    e.stl  = 8'(stl);
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //     name            rst en md tv   T   dx dxv ed ev | st  eT ini dto dv stl
    step("reset",          1, 0, 0, 0,   0,  0, 0,  0, 0,   0,  0, 0,  0, 0, 0);
    step("ext",            0, 1, 0, 0,   0, -5, 1,  0, 0,   0,  0, 0, -5, 1, 0);
    step("ext_tv_ignore",  0, 1, 0, 1,  33,  7, 0,  0, 0,   0,  0, 0,  7, 0, 0);
    step("disable",        0, 0, 0, 0,   0,  9, 1,  0, 0,   0,  0, 0,  7, 0, 0);
    step("mode_idle",      0, 1, 1, 0,   0,  9, 1,  0, 0,   0,  0, 0,  7, 0, 0);
    step("init",           0, 1, 1, 1,  20,  0, 0,  0, 0,   1, 20, 1,  7, 0, 0);
    step("warm_gap",       0, 1, 1, 0,   0,  0, 0,  3, 1,   1, 20, 0,  7, 0, 0);
    step("warm_21",        0, 1, 1, 1,  21,  0, 0,  3, 1,   1, 21, 0,  7, 0, 0);
    step("warm_22",        0, 1, 1, 1,  22,  0, 0,  3, 1,   1, 22, 0,  7, 0, 0);
    step("warm_23",        0, 1, 1, 1,  23,  0, 0,  3, 1,   1, 23, 0,  7, 0, 0);
    step("warm_24_run",    0, 1, 1, 1,  24,  0, 0,  3, 1,   2, 24, 0,  7, 0, 0);
    step("run_pass",       0, 1, 1, 0,   0,  0, 0,  3, 1,   2, 24, 0,  3, 1, 0);
    step("run_sample",     0, 1, 1, 1,  25,  0, 0, -2, 0,   2, 25, 0, -2, 0, 0);
    for (int i = 0; i < 15; i++)
      step("run_wait",     0, 1, 1, 0,   0,  0, 0,  4, 1,   2, 25, 0,  4, 1, 0);
    step("timeout",        0, 1, 1, 0,   0,  0, 0,  4, 1,   0, 25, 0,  4, 0, 1);
    step("stale_idle",     0, 1, 1, 0,   0,  0, 0,  4, 1,   0, 25, 0,  4, 0, 1);
    step("reinit",         0, 1, 1, 1, -10,  0, 0,  4, 1,   1,-10, 1,  4, 0, 0);
    step("rewarm_1",       0, 1, 1, 1,   1,  0, 0,  4, 1,   1,  1, 0,  4, 0, 0);
    step("rewarm_2",       0, 1, 1, 1,   2,  0, 0,  4, 1,   1,  2, 0,  4, 0, 0);
    step("rewarm_3",       0, 1, 1, 1,   3,  0, 0,  4, 1,   1,  3, 0,  4, 0, 0);
    step("rewarm_4_run",   0, 1, 1, 1,   4,  0, 0,  4, 1,   2,  4, 0,  4, 0, 0);
    for (int i = 0; i < 15; i++)
      step("race_wait",    0, 1, 1, 0,   0,  0, 0,  6, 1,   2,  4, 0,  6, 1, 0);
    step("race_sample",    0, 1, 1, 1,   5,  0, 0,  6, 1,   2,  5, 0,  6, 1, 0);
    for (int i = 0; i < 15; i++)
      step("race_after",   0, 1, 1, 0,   0,  0, 0,  6, 1,   2,  5, 0,  6, 1, 0);
    step("timeout2",       0, 1, 1, 0,   0,  0, 0,  6, 1,   0,  5, 0,  6, 0, 1);
    step("init3",          0, 1, 1, 1,  30,  0, 0,  6, 1,   1, 30, 1,  6, 0, 0);
    step("abort_warm",     0, 1, 0, 1,  50, 11, 1,  6, 1,   0, 30, 0, 11, 1, 0);
    step("init4",          0, 1, 1, 1,  40,  0, 0,  6, 1,   1, 40, 1, 11, 0, 0);
    step("warm4_41",       0, 1, 1, 1,  41,  0, 0,  6, 1,   1, 41, 0, 11, 0, 0);
    step("warm4_42",       0, 1, 1, 1,  42,  0, 0,  6, 1,   1, 42, 0, 11, 0, 0);
    step("warm4_43",       0, 1, 1, 1,  43,  0, 0,  6, 1,   1, 43, 0, 11, 0, 0);
    step("warm4_44",       0, 1, 1, 1,  44,  0, 0,  6, 1,   2, 44, 0, 11, 0, 0);
    step("run4_pass",      0, 1, 1, 0,   0,  0, 0,  8, 1,   2, 44, 0,  8, 1, 0);
    step("reset_run",      1, 1, 1, 0,   0,  0, 0,  8, 1,   0,  0, 0,  0, 0, 0);
    step("post_reset",     0, 1, 1, 0,   0,  0, 0,  8, 1,   0,  0, 0,  0, 0, 0);

    // Drain: the monitor must consume every queued expectation in bounded time.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dt_mode_ctrl.md
Name: dt_mode_ctrl

Overview:
Controller that sequences the internal dT estimator and selects the dT source presented to downstream logic. It captures sensor samples into a held estimator input. It issues the estimator's one-cycle init pulse on (re)start, enforces a warm-up period, and detects a stalled sensor (stale). It also muxes the final dT between the external dT input (DT_MODE=0) and the estimator output (DT_MODE=1).

Parameters:
WARM_SAMPLES, 4, post-init samples before estimator output is trusted (legal range 1..255)
TIMEOUT_CYC, 1024, max cycles between t_valid strobes in RUN before stale; 0 disables timeout
CW, 16, timeout counter width; must hold TIMEOUT_CYC

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  block enable; low forces IDLE
dt_mode  in  1  0 = external dT, 1 = internal estimator
t_valid  in  1  one-cycle sensor sample strobe
T_in  in  8  signed temperature sample, Q7.0
dT_ext  in  8  signed external dT, Q7.0
dT_ext_valid  in  1  external dT valid
est_dT  in  8  signed estimator output, Q7.0
est_valid  in  1  estimator valid
est_T  out  8  signed held sample to estimator T_cur, Q7.0
est_init  out  1  one-cycle init pulse to estimator
dT_out  out  8  signed selected dT, Q7.0
dT_valid  out  1  dT_out valid
state  out  2  0=IDLE, 1=WARM, 2=RUN
stale  out  1  sticky: sample timeout occurred in RUN

Behaviour:
- All outputs are registered. Reset (rst=1 at a clk edge) from any state:
  - state=IDLE; est_T=0, est_init=0, dT_out=0, dT_valid=0, stale=0.
  - warm_cnt=0, to_cnt=0.
- Global abort:
  - enable=0 or dt_mode=0 moves the FSM to IDLE from any state in the next cycle.
  - No init pulse is issued. This takes priority over a same-cycle t_valid, and the sample is ignored.
- est_init defaults to 0 and is high for exactly one cycle per init.
- External path (enable=1, dt_mode=0):
  - Each cycle, dT_out<=dT_ext and dT_valid<=dT_ext_valid. Latency is 1 cycle.
  - est_T holds its value; the FSM stays in IDLE.
- enable=0: dT_valid<=0; dT_out holds.
- IDLE with enable=1 and dt_mode=1:
  - dT_valid<=0.
  - On t_valid: est_T<=T_in, est_init<=1, stale<=0, warm_cnt<=0, go to WARM. est_init and the new est_T appear in the same cycle.
- WARM:
  - dT_valid<=0.
  - On t_valid: est_T<=T_in and warm_cnt++.
  - When a t_valid occurs with warm_cnt==WARM_SAMPLES-1, go to RUN and set to_cnt<=0.
  - WARM has no timeout.
- RUN:
  - Each cycle, dT_out<=est_dT and dT_valid<=est_valid. Latency is 1 cycle.
  - On t_valid: est_T<=T_in and to_cnt<=0; otherwise to_cnt++ (saturating).
  - If TIMEOUT_CYC!=0, no t_valid this cycle, and to_cnt==TIMEOUT_CYC-1: stale<=1, dT_valid<=0, go to IDLE.
  - A t_valid in the same cycle as the timeout wins: the counter resets and there is no stale.
- stale clears only on the next init, or on rst.
- dt_mode 0->1 while enable=1:
  - FSM is already in IDLE; dT_valid drops to 0 the following cycle.
  - The first subsequent t_valid triggers init.
- est_T changes only on an accepted t_valid. It is never modified in the external path.
- No arithmetic on dT values: pure selection. Widths are preserved and signedness is untouched.

Test Plan:
- Reset then external mode: dt_mode=0, dT_ext=-5, dT_ext_valid=1 -> next cycle dT_out=-5, dT_valid=1, state=0, est_init never asserted.
- Init/warm: dt_mode=1, WARM_SAMPLES=4, t_valid with T_in=20 then samples 21,22,23,24 -> est_init=1 for one cycle with est_T=20; state=WARM until the 4th post-init sample; RUN after T_in=24; dT_valid=0 throughout WARM.
- RUN passthrough: est_dT=3, est_valid=1 in RUN -> dT_out=3, dT_valid=1 one cycle later; est_T tracks each t_valid value.
- Timeout: TIMEOUT_CYC=16, no t_valid for 16 cycles in RUN -> stale=1, state=IDLE, dT_valid=0. Next t_valid (T_in=-10) -> est_init pulse, est_T=-10, stale=0.
- Timeout race: t_valid on the exact timeout cycle -> stays in RUN, stale=0, to_cnt reset.
- Abort/reset mid-operation: dt_mode 1->0 in WARM coincident with t_valid (T_in=50) -> IDLE, est_T unchanged, no init. A separate rst=1 in RUN -> all outputs 0 on the next edge.
